// File: rtl/fwd_hazard_unit_p.sv
// Forwarding/hazard unit: shadow pipe of destination tags from EX through NUM_FWD
// stages, registered EX forwarding selects, load-use stalls and multiplier interlock.
module fwd_hazard_unit_p #(
    parameter int REG_AW     = 5,
    parameter int NUM_FWD    = 2,
    parameter int LOAD_STAGE = 2,
    parameter int MUL_LAT    = 4,
    parameter int SEL_W      = 3
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              ID_Valid,
    input  logic [REG_AW-1:0] ID_Rs,
    input  logic [REG_AW-1:0] ID_Rt,
    input  logic              ID_UsesRs,
    input  logic              ID_UsesRt,
    input  logic [REG_AW-1:0] ID_Rd,
    input  logic              ID_RegWrite,
    input  logic              ID_IsLoad,
    input  logic              ID_IsMul,
    input  logic              Flush,
    output logic              Stall,
    output logic [SEL_W-1:0]  EX_SelA,
    output logic [SEL_W-1:0]  EX_SelB,
    output logic              MulBusy,
    output logic              MulDone
);

    // state | meaning
    // IDLE  | no multiply outstanding
    // BUSY  | multiply in flight, mul_cnt cycles left before its result is written
    typedef enum logic {
        IDLE,
        BUSY
    } mul_state_t;

    localparam int CNT_W = $clog2(MUL_LAT);

    // slot 0 is the EX slot, slot k is downstream stage k
    logic [REG_AW-1:0] slot_rd   [0:NUM_FWD];
    logic              slot_wen  [0:NUM_FWD];
    logic              slot_load [0:NUM_FWD];

    mul_state_t        mul_state;
    logic [CNT_W-1:0]  mul_cnt;
    logic [REG_AW-1:0] mul_rd;
    logic              mul_wen;

    logic [SEL_W-1:0]  sel_a;
    logic [SEL_W-1:0]  sel_b;
    logic              lu_a;
    logic              lu_b;
    logic              mul_lock;
    logic              accept;

    // Scan oldest to youngest so the youngest matching producer overrides.
    function automatic logic [SEL_W:0] resolve(input logic [REG_AW-1:0] src,
                                               input logic              used);
        logic [SEL_W:0] res;
        res = '0;
        if (used && src != '0) begin
            for (int k = NUM_FWD; k >= 0; k--) begin
                if (slot_wen[k] && slot_rd[k] == src) begin
                    res[SEL_W-1:0] = (k < NUM_FWD) ? SEL_W'(k + 1) : '0;
                    res[SEL_W]     = slot_load[k] && (k + 1 < LOAD_STAGE);
                end
            end
        end
        return res;
    endfunction

    always_comb begin
        {lu_a, sel_a} = resolve(ID_Rs, ID_UsesRs);
        {lu_b, sel_b} = resolve(ID_Rt, ID_UsesRt);
    end

    // The done cycle (counter at 0) releases dependents to the write-through regfile.
    always_comb begin
        mul_lock = 1'b0;
        if (mul_state == BUSY && mul_cnt != '0) begin
            mul_lock = ID_IsMul ||
                       (mul_wen && mul_rd != '0 &&
                        ((ID_UsesRs   && ID_Rs == mul_rd) ||
                         (ID_UsesRt   && ID_Rt == mul_rd) ||
                         (ID_RegWrite && ID_Rd == mul_rd)));
        end
    end

    assign Stall   = ID_Valid && !Flush && (lu_a || lu_b || mul_lock);
    assign accept  = ID_Valid && !Stall && !Flush;
    assign MulBusy = (mul_state == BUSY);

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int k = 0; k <= NUM_FWD; k++) begin
                slot_rd[k]   <= '0;
                slot_wen[k]  <= 1'b0;
                slot_load[k] <= 1'b0;
            end
            EX_SelA <= '0;
            EX_SelB <= '0;
        end else begin
            for (int k = 1; k <= NUM_FWD; k++) begin
                slot_rd[k]   <= slot_rd[k-1];
                slot_wen[k]  <= slot_wen[k-1];
                slot_load[k] <= slot_load[k-1];
            end
            slot_rd[0]   <= ID_Rd;
            slot_wen[0]  <= accept && !ID_IsMul && ID_RegWrite;
            slot_load[0] <= accept && !ID_IsMul && ID_IsLoad;
            EX_SelA      <= accept ? sel_a : '0;
            EX_SelB      <= accept ? sel_b : '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            mul_state <= IDLE;
            mul_cnt   <= '0;
            mul_rd    <= '0;
            mul_wen   <= 1'b0;
            MulDone   <= 1'b0;
        end else begin
            MulDone <= (mul_state == BUSY) && (mul_cnt == CNT_W'(1));
            if (accept && ID_IsMul) begin
                // a new mul may issue on the done cycle and restarts the count
                mul_state <= BUSY;
                mul_cnt   <= CNT_W'(MUL_LAT - 1);
                mul_rd    <= ID_Rd;
                mul_wen   <= ID_RegWrite;
            end else if (mul_state == BUSY) begin
                if (mul_cnt == '0) begin
                    mul_state <= IDLE;
                end else begin
                    mul_cnt <= mul_cnt - 1'b1;
                end
            end
        end
    end

endmodule
